mult_issue_ctrl: RTL and testbench

Operand issue and result capture stage placed directly upstream of the team's 32x32 signed shift-add multiplier.
- Buffers signed operand pairs from a valid/ready producer in a small FIFO.
- Drives the multiplier's level-held start protocol and holds the operands stable while it runs.
- Captures the 64-bit product when the multiplier raises valid and presents it on a valid/ready result port.
- Guarantees the start-low gap the multiplier needs to re-arm between operations.

---
 rtl/mult_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// Operand FIFO and start/valid sequencer in front of the 32x32 signed shift-add multiplier.
// Define MULT_TIMEOUT_EN to add the RUN watchdog (abort after TIMEOUT cycles, sticky timeout_err).
module mult_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_mlier,
  input  logic [31:0]      in_mcand,
  output logic [31:0]      mul_mlier,
  output logic [31:0]      mul_mcand,
  output logic             mul_start,
  input  logic [63:0]      mul_prodt,
  input  logic             mul_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_prodt,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             timeout_err
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, RESULT, RECOVER} state_e;

  state_e           state_q, state_d;
  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mlier_q, mlier_d;
  logic [31:0]      mcand_q, mcand_d;
  logic             start_q, start_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      prodt_q, prodt_d;
  logic             push, pop;
  logic [63:0]      head;

`ifdef MULT_TIMEOUT_EN
  localparam int RC_W = $clog2(TIMEOUT + 1);
  logic [RC_W-1:0]  run_cnt_q, run_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`else
  logic             unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // No push-through when full: in_ready ignores a same-cycle pop.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    mlier_d     = mlier_q;
    mcand_d     = mcand_q;
    out_valid_d = out_valid_q;
    prodt_d     = prodt_q;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
`ifdef MULT_TIMEOUT_EN
    run_cnt_d     = run_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          mlier_d = head[63:32];
          mcand_d = head[31:0];
          state_d = RUN;
`ifdef MULT_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end
      end
      RUN: begin
        if (mul_valid) begin
          prodt_d     = mul_prodt;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end
`ifdef MULT_TIMEOUT_EN
        else if (run_cnt_q == RC_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = RECOVER;
        end else begin
          run_cnt_d = run_cnt_q + RC_W'(1);
        end
`endif
      end
      RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Start is a registered copy of "next state is RUN", so it drops the cycle RUN ends.
    start_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_mlier, in_mcand};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mlier_q     <= '0;
      mcand_q     <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      prodt_q     <= '0;
`ifdef MULT_TIMEOUT_EN
      run_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mlier_q     <= mlier_d;
      mcand_q     <= mcand_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      prodt_q     <= prodt_d;
`ifdef MULT_TIMEOUT_EN
      run_cnt_q     <= run_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign mul_mlier  = mlier_q;
  assign mul_mcand  = mcand_q;
  assign mul_start  = start_q;
  assign out_valid  = out_valid_q;
  assign out_prodt  = prodt_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;
`ifdef MULT_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl with a behavioural 33-cycle multiplier and an in-order result scoreboard.
module tb_mult_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 64;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_mlier = '0;
  logic [31:0]      in_mcand = '0;
  logic [31:0]      mul_mlier;
  logic [31:0]      mul_mcand;
  logic             mul_start;
  logic [63:0]      mul_prodt;
  logic             mul_valid;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [63:0]      out_prodt;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             timeout_err;

  int n_checks = 0;
  int n_fail = 0;
  int n_results = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t tbl [8];

  mult_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mlier(in_mlier), .in_mcand(in_mcand),
    .mul_mlier(mul_mlier), .mul_mcand(mul_mcand), .mul_start(mul_start),
    .mul_prodt(mul_prodt), .mul_valid(mul_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_prodt(out_prodt),
    .busy(busy), .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Multiplier model: valid rises after 33 start-high cycles, clears when start drops.
  int          mcnt = 0;
  logic        mvalid = 1'b0;
  logic [63:0] mprod = '0;
  logic        mul_never = 1'b0;
  logic [63:0] ma, mb;
  assign ma = {{32{mul_mlier[31]}}, mul_mlier};
  assign mb = {{32{mul_mcand[31]}}, mul_mcand};
  assign mul_prodt = mprod;
  assign mul_valid = mvalid;

  always @(posedge clock) begin
    if (!reset_n || !mul_start) begin
      mcnt   <= 0;
      mvalid <= 1'b0;
    end else if (mcnt == 32) begin
      mvalid <= !mul_never;
      mprod  <= ma * mb;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      n_results++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got out_prodt=%h, required no result", out_prodt);
      end else begin
        chk("result", out_prodt, exp_q.pop_front());
      end
      $display("result %0d: out_prodt=%h", n_results, out_prodt);
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_mlier = a;
    in_mcand = b;
    while (!in_ready && w < 400) begin
      @(posedge clock); #1;
      w++;
    end
    chk("push_ready", 64'(in_ready), 64'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    $display("push mlier=%h mcand=%h", a, b);
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while ((busy || fifo_count != '0 || exp_q.size() != 0) && w < budget) begin
      @(posedge clock); #1;
      w++;
    end
    chk("drain_in_budget", 64'(w < budget), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [63:0] held;
    int ai, bi;

    tbl[0] = '{a: 32'd7,          b: 32'hFFFF_FFFD, p: 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1] = '{a: 32'd2,          b: 32'd3,         p: 64'd6};
    tbl[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF, p: 64'd1};
    tbl[3] = '{a: 32'd0,          b: 32'd12345,     p: 64'd0};
    tbl[4] = '{a: 32'h8000_0000,  b: 32'd1,         p: 64'hFFFF_FFFF_8000_0000};
    tbl[5] = '{a: 32'h7FFF_FFFF,  b: 32'h7FFF_FFFF, p: 64'h3FFF_FFFF_0000_0001};
    tbl[6] = '{a: 32'd100,        b: 32'hFFFF_FF9C, p: 64'hFFFF_FFFF_FFFF_D8F0};
    tbl[7] = '{a: 32'h8000_0000,  b: 32'h8000_0000, p: 64'h4000_0000_0000_0000};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fifo_count", 64'(fifo_count), 64'(0));
    chk("rst_mul_start", 64'(mul_start), 64'(0));
    chk("rst_mul_mlier", 64'(mul_mlier), 64'(0));
    chk("rst_mul_mcand", 64'(mul_mcand), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_prodt", out_prodt, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    reset_n = 1'b1;

    // Single operation: latency from push edge to out_valid
    exp_q.push_back(tbl[0].p);
    push(tbl[0].a, tbl[0].b);
    @(posedge clock); #1;
    chk("issue_start", 64'(mul_start), 64'(1));
    chk("issue_mlier", 64'(mul_mlier), 64'(tbl[0].a));
    chk("issue_mcand", 64'(mul_mcand), 64'(tbl[0].b));
    chk("issue_count", 64'(fifo_count), 64'(0));
    k = 1;
    while (!out_valid && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    chk("latency", 64'(k), 64'(35));
    chk("result_start_low", 64'(mul_start), 64'(0));
    @(posedge clock); #1;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_out_valid", 64'(out_valid), 64'(0));

    // Back-to-back burst of five into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(tbl[i].p);
      push(tbl[i].a, tbl[i].b);
    end
    chk("burst_count_full", 64'(fifo_count), 64'(DEPTH));
    chk("burst_in_ready_low", 64'(in_ready), 64'(0));
    wait_idle(600);

    // Result back-pressure for 20 cycles
    out_ready = 1'b0;
    exp_q.push_back(tbl[6].p);
    push(tbl[6].a, tbl[6].b);
    exp_q.push_back(tbl[7].p);
    push(tbl[7].a, tbl[7].b);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    held = out_prodt;
    chk("bp_prodt", held, tbl[6].p);
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      chk("bp_prodt_stable", out_prodt, held);
      chk("bp_start_low", 64'(mul_start), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_queued", 64'(fifo_count), 64'(1));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("hs_out_valid", 64'(out_valid), 64'(0));
    chk("hs_start_low", 64'(mul_start), 64'(0));
    chk("hs_count", 64'(fifo_count), 64'(1));
    @(posedge clock); #1;
    chk("hs_next_start", 64'(mul_start), 64'(1));
    chk("hs_next_mlier", 64'(mul_mlier), 64'(tbl[7].a));
    chk("hs_next_count", 64'(fifo_count), 64'(0));
    wait_idle(200);

    // Reset pulse mid-RUN with three entries queued
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tbl[i].p);
      push(tbl[i].a, tbl[i].b);
    end
    repeat (5) @(posedge clock);
    #1;
    chk("mid_run_busy", 64'(busy), 64'(1));
    chk("mid_run_count", 64'(fifo_count), 64'(3));
    reset_n = 1'b0;
    exp_q.delete();
    k = n_results;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("rst2_count", 64'(fifo_count), 64'(0));
    chk("rst2_start", 64'(mul_start), 64'(0));
    chk("rst2_out_valid", 64'(out_valid), 64'(0));
    chk("rst2_busy", 64'(busy), 64'(0));
    repeat (80) @(posedge clock);
    #1;
    chk("rst2_no_result", 64'(n_results), 64'(k));

    // Simultaneous push/pop at count 2, 13 transactions to wrap pointers 3 times
    for (int i = 0; i < 13; i++) begin
      ai = 17 * i - 100;
      bi = 3 - 29 * i * i;
      exp_q.push_back(64'(longint'(ai) * longint'(bi)));
      if (i < 3) begin
        push(32'(ai), 32'(bi));
      end else begin
        k = 0;
        while (!(busy == 1'b0 && fifo_count == CNT_W'(2)) && k < 200) begin
          @(posedge clock); #1;
          k++;
        end
        in_valid = 1'b1;
        in_mlier = 32'(ai);
        in_mcand = 32'(bi);
        @(posedge clock); #1;
        in_valid = 1'b0;
        $display("push+pop mlier=%h mcand=%h", 32'(ai), 32'(bi));
        chk("pushpop_count", 64'(fifo_count), 64'(2));
        chk("pushpop_start", 64'(mul_start), 64'(1));
      end
    end
    wait_idle(1200);

`ifdef MULT_TIMEOUT_EN
    // Watchdog abort: first pair never completes, second is issued after one RECOVER cycle
    mul_never = 1'b1;
    push(tbl[1].a, tbl[1].b);
    push(tbl[2].a, tbl[2].b);
    chk("to_start", 64'(mul_start), 64'(1));
    k = 0;
    while (!timeout_err && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    chk("to_latency", 64'(k), 64'(TIMEOUT));
    chk("to_recover_start", 64'(mul_start), 64'(0));
    chk("to_recover_busy", 64'(busy), 64'(1));
    chk("to_no_out_valid", 64'(out_valid), 64'(0));
    @(posedge clock); #1;
    chk("to_idle_busy", 64'(busy), 64'(0));
    @(posedge clock); #1;
    chk("to_next_start", 64'(mul_start), 64'(1));
    chk("to_next_mlier", 64'(mul_mlier), 64'(tbl[2].a));
    mul_never = 1'b0;
    exp_q.push_back(tbl[2].p);
    wait_idle(200);
    chk("to_sticky", 64'(timeout_err), 64'(1));
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("to_cleared", 64'(timeout_err), 64'(0));
`else
    chk("no_timeout_err", 64'(timeout_err), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
